// File: rtl/serial_adder_nb.sv
// serial_adder_nb
//   Multi-cycle WIDTH-bit adder/subtractor. A chain of SLICE full-adder cells
//   processes SLICE bits per clock, LSB slice first. The carry is held in a
//   register between slices. Operation is controlled by a start/busy/done
//   handshake.
//
//   Optional feature macro: SERIAL_ADDER_ZERO_FLAG_EN adds the 'zero' output.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request an operation (sampled only when busy==0)
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   c_in   in   carry in for add (ignored for subtract)
//   sub    in   0: a+b+c_in, 1: a-b
//   busy   out  operation in flight
//   done   out  one-cycle pulse when sum/c_out/ofl update
//   sum    out  last completed result
//   c_out  out  carry out of the MSB (for subtract, 1 = no borrow)
//   ofl    out  signed overflow of the last result
//   zero   out  last completed sum == 0 (only with SERIAL_ADDER_ZERO_FLAG_EN)
module serial_adder_nb #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ofl
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("serial_adder_nb: WIDTH must be a multiple of SLICE and 1 <= SLICE <= WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] psum_reg, psum_next;
  logic             a_msb_reg, a_msb_next;
  logic             b_msb_reg, b_msb_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             c_out_reg, c_out_next;
  logic             ofl_reg, ofl_next;
  logic             zero_reg, zero_next;

  // Ripple chain of SLICE full adders over the low bits of the shifting operands.
  logic [SLICE:0]   chain;
  logic [SLICE-1:0] slice_sum;
  logic [WIDTH-1:0] psum_shift;

  assign chain[0] = carry_reg;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
    assign slice_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
    assign chain[gi+1]   = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
  end

  // New slice enters from the top so that after STEPS shifts the LSB slice
  // has arrived at bit 0.
  if (SLICE == WIDTH) begin : g_psum_full
    assign psum_shift = slice_sum;
  end else begin : g_psum_shift
    assign psum_shift = {slice_sum, psum_reg[WIDTH-1:SLICE]};
  end

  // Start is honoured in IDLE and also in DONE, which allows back-to-back ops.
  logic accept;
  assign accept = start && (state_reg != RUN);

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    psum_next  = psum_reg;
    a_msb_next = a_msb_reg;
    b_msb_next = b_msb_reg;
    sum_next   = sum_reg;
    c_out_next = c_out_reg;
    ofl_next   = ofl_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: state_next = IDLE;
      RUN: begin
        a_next     = a_reg >> SLICE;
        b_next     = b_reg >> SLICE;
        carry_next = chain[SLICE];
        psum_next  = psum_shift;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST) begin
          state_next = DONE;
          sum_next   = psum_shift;
          c_out_next = chain[SLICE];
          ofl_next   = (a_msb_reg == b_msb_reg) && (psum_shift[WIDTH-1] != a_msb_reg);
          zero_next  = (psum_shift == '0);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (accept) begin
      state_next = RUN;
      a_next     = a;
      b_next     = sub ? ~b : b;
      carry_next = sub ? 1'b1 : c_in;
      cnt_next   = '0;
      psum_next  = '0;
      a_msb_next = a[WIDTH-1];
      b_msb_next = sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      psum_reg  <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ofl_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      psum_reg  <= psum_next;
      a_msb_reg <= a_msb_next;
      b_msb_reg <= b_msb_next;
      sum_reg   <= sum_next;
      c_out_reg <= c_out_next;
      ofl_reg   <= ofl_next;
      zero_reg  <= zero_next;
    end
  end

  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);
  assign sum   = sum_reg;
  assign c_out = c_out_reg;
  assign ofl   = ofl_reg;

`ifdef SERIAL_ADDER_ZERO_FLAG_EN
  assign zero = zero_reg;
`else
  logic unused_zero;
  assign unused_zero = zero_reg;
`endif

endmodule

// File: tb/tb_serial_adder_nb.sv
// Testbench for serial_adder_nb (WIDTH=16, SLICE=4).
module tb_serial_adder_nb;

  localparam int W     = 16;
  localparam int S     = 4;
  localparam int STEPS = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ofl;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
  logic         zero;
`endif

  serial_adder_nb #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ofl   (ofl)
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    ,
    .zero  (zero)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer arithmetic on the operation's definition.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mc, input logic ms,
                       output logic [W-1:0] s, output logic co,
                       output logic o, output logic z);
    logic [W-1:0] beff;
    logic         cin;
    logic [W:0]   full;
    int           t;
    beff = ms ? ~mb : mb;
    cin  = ms ? 1'b1 : mc;
    full = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, cin};
    s    = full[W-1:0];
    co   = full[W];
    t    = int'($signed(ma)) + int'($signed(beff)) + int'(cin);
    o    = (t > 32767) || (t < -32768);
    z    = (s == '0);
  endtask

  // Drive an operation; start is accepted at the following rising edge.
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb,
                        input logic lc, input logic ls);
    @(negedge clk);
    a = la; b = lb; c_in = lc; sub = ls; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges until done is seen, or -1 if the budget expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'hABCD; b = 16'h1111; c_in = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b want 0", c_out); end
    checks++; if (ofl !== 1'b0) begin errors++; $display("FAIL reset_ofl: got %b want 0", ofl); end
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero); end
`endif
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    $display("reset: busy=%b done=%b sum=%h c_out=%b ofl=%b", busy, done, sum, c_out, ofl);
  endtask

  task automatic test_directed;
    logic [W-1:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [W-1:0] vb [5] = '{16'h4321, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
    logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] held = 16'h0;
    int lat;
    for (int i = 0; i < 5; i++) begin
      launch(va[i], vb[i], vc[i], vs[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy: got %b want 1", i, busy); end
      checks++; if (sum !== held) begin errors++; $display("FAIL dir%0d_hold: got %h want %h", i, sum, held); end
      wait_done(lat);
      checks++; if (lat != STEPS) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, STEPS); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum: got %h want %h", i, sum, es[i]); end
      checks++; if (c_out !== ec[i]) begin errors++; $display("FAIL dir%0d_c_out: got %b want %b", i, c_out, ec[i]); end
      checks++; if (ofl !== eo[i]) begin errors++; $display("FAIL dir%0d_ofl: got %b want %b", i, ofl, eo[i]); end
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
      checks++; if (zero !== (es[i] == 16'h0)) begin errors++; $display("FAIL dir%0d_zero: got %b want %b", i, zero, es[i] == 16'h0); end
`endif
      $display("directed %0d: a=%h b=%h c_in=%b sub=%b -> sum=%h c_out=%b ofl=%b lat=%0d",
               i, va[i], vb[i], vc[i], vs[i], sum, c_out, ofl, lat);
      held = es[i];
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
      checks++; if (sum !== held) begin errors++; $display("FAIL dir%0d_idle_hold: got %h want %h", i, sum, held); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb, es;
    logic rc, rs, ec, eo, ez;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      model(ra, rb, rc, rs, es, ec, eo, ez);
      launch(ra, rb, rc, rs);
      wait_done(lat);
      checks++; if (lat != STEPS) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, STEPS); end
      checks++; if (sum !== es) begin errors++; $display("FAIL rnd%0d_sum: got %h want %h", i, sum, es); end
      checks++; if (c_out !== ec) begin errors++; $display("FAIL rnd%0d_c_out: got %b want %b", i, c_out, ec); end
      checks++; if (ofl !== eo) begin errors++; $display("FAIL rnd%0d_ofl: got %b want %b", i, ofl, eo); end
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
      checks++; if (zero !== ez) begin errors++; $display("FAIL rnd%0d_zero: got %b want %b", i, zero, ez); end
`endif
      $display("random %0d: a=%h b=%h c_in=%b sub=%b -> sum=%h c_out=%b ofl=%b", i, ra, rb, rc, rs, sum, c_out, ofl);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_busy_ignore;
    logic [W-1:0] es;
    logic ec, eo, ez;
    int lat;
    model(16'h2468, 16'h1357, 1'b1, 1'b0, es, ec, eo, ez);
    launch(16'h2468, 16'h1357, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); sub = 1'b1; c_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy%0d: got %b want 1", k, busy); end
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat != STEPS - 3) begin errors++; $display("FAIL ign_latency: got %0d want %0d", lat, STEPS - 3); end
    checks++; if (sum !== es) begin errors++; $display("FAIL ign_sum: got %h want %h", sum, es); end
    checks++; if (c_out !== ec) begin errors++; $display("FAIL ign_c_out: got %b want %b", c_out, ec); end
    checks++; if (ofl !== eo) begin errors++; $display("FAIL ign_ofl: got %b want %b", ofl, eo); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy=%b done=%b want 0/0", busy, done); end
    $display("busy_ignore: sum=%h c_out=%b ofl=%b", sum, c_out, ofl);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] s1, s2;
    logic c1, o1, z1, c2, o2, z2;
    int lat;
    model(16'h00FF, 16'h0F01, 1'b0, 1'b0, s1, c1, o1, z1);
    model(16'h8000, 16'h0001, 1'b0, 1'b1, s2, c2, o2, z2);
    launch(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat != STEPS) begin errors++; $display("FAIL b2b_lat1: got %0d want %0d", lat, STEPS); end
    checks++; if (sum !== s1) begin errors++; $display("FAIL b2b_sum1: got %h want %h", sum, s1); end
    // Request the next op during the done cycle.
    a = 16'h8000; b = 16'h0001; c_in = 1'b0; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got busy=%b want 1", busy); end
    checks++; if (sum !== s1) begin errors++; $display("FAIL b2b_hold: got %h want %h", sum, s1); end
    wait_done(lat);
    checks++; if (lat != STEPS) begin errors++; $display("FAIL b2b_lat2: got %0d want %0d", lat, STEPS); end
    checks++; if (sum !== s2) begin errors++; $display("FAIL b2b_sum2: got %h want %h", sum, s2); end
    checks++; if (c_out !== c2) begin errors++; $display("FAIL b2b_c_out2: got %b want %b", c_out, c2); end
    checks++; if (ofl !== o2) begin errors++; $display("FAIL b2b_ofl2: got %b want %b", ofl, o2); end
    $display("back_to_back: first=%h second=%h c_out=%b ofl=%b", s1, sum, c_out, ofl);
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] es;
    logic ec, eo, ez;
    int lat;
    int pulses;
    // Leave nonzero flags behind so the clear is observable.
    launch(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(lat);
    checks++; if (sum !== 16'h7FFF || ofl !== 1'b1) begin errors++; $display("FAIL rmid_prep: got sum=%h ofl=%b want 7fff/1", sum, ofl); end
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
    checks++; if (sum !== 16'h0 || c_out !== 1'b0 || ofl !== 1'b0) begin
      errors++; $display("FAIL rmid_clear: got sum=%h c_out=%b ofl=%b want 0000/0/0", sum, c_out, ofl);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses want 0", pulses); end
    model(16'h1111, 16'h2222, 1'b1, 1'b0, es, ec, eo, ez);
    launch(16'h1111, 16'h2222, 1'b1, 1'b0);
    wait_done(lat);
    checks++; if (lat != STEPS) begin errors++; $display("FAIL rmid_lat: got %0d want %0d", lat, STEPS); end
    checks++; if (sum !== es || c_out !== ec || ofl !== eo) begin
      errors++; $display("FAIL rmid_after: got sum=%h c_out=%b ofl=%b want %h/%b/%b", sum, c_out, ofl, es, ec, eo);
    end
    $display("reset_mid: pulses=%0d after_sum=%h", pulses, sum);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
